dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for CPU load/store traffic: accepts one request at a time over a
//  valid/ready channel, services it against an internal word array after a fixed latency,
//  and returns read data or a write acknowledge over a second valid/ready channel.
//  Sits between the datapath's address/write-data/MemRead/MemWrite outputs and storage, for
//  multi-cycle CPU variants that stall on resp_valid.
// PARAMETERS
//  DATA_W   64   data word width in bits
//  ADDR_W   64   byte-address width
//  DEPTH    256  number of DATA_W words; word index = req_addr[ADDR_W-1:3]
//  LATENCY  2    cycles from request accept edge to resp_valid high; legal range 1..15
// PORTS
//  clk         in   1       single clock; all state updates on rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       responder can accept a request (high only in IDLE)
//  req_write   in   1       1 = store (MemWrite), 0 = load (MemRead)
//  req_addr    in   ADDR_W  byte address (ALU result)
//  req_wdata   in   DATA_W  store data (ReadData2)
//  resp_valid  out  1       response present
//  resp_ready  in   1       requester consumes response
//  resp_rdata  out  DATA_W  load data; 0 for stores and errors
//  resp_err    out  1       request was misaligned or out of range
// BEHAVIOUR
//  - Reset (reset_n low, async): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0,
//    resp_err=0, latency counter=0. Array contents are not affected by reset.
//  - FSM: IDLE -> (req_valid & req_ready) -> WAIT if LATENCY>1, else RESP.
//    WAIT: counter loaded with LATENCY-1 at accept, decrements each cycle; at 1 -> RESP.
//    RESP: resp_valid=1, outputs stable; (resp_valid & resp_ready) -> IDLE.
//  - Accept edge latches req_write/req_addr/req_wdata; inputs are don't-care afterwards.
//  - resp_valid rises exactly LATENCY cycles after the accept edge.
//  - Error check on latched address: err = (addr[2:0]!=0) | (addr[ADDR_W-1:3] >= DEPTH).
//  - Store commits to the array on the edge entering RESP, only if err=0; resp_rdata=0.
//  - Load reads the array on the edge entering RESP (value includes any earlier committed
//    store); err=1 forces resp_rdata=0.
//  - No pipelining: one outstanding request; req_ready=0 in WAIT and RESP. Minimum spacing
//    between accepts is LATENCY+1 cycles with resp_ready held high.
//  - resp_ready low in RESP: hold all response outputs indefinitely, no state change.
//  - req_valid high while busy: ignored, not queued; requester must hold it until accepted.
//  - Reset mid-operation (WAIT or RESP): request is dropped; an uncommitted store never
//    reaches the array; resp_valid deasserts immediately (async).
//  - Invalid LATENCY (0 or >15) is a compile-time error.
// STRUCTURE
//  - Package dmem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2), WORD_OFS_BITS=3,
//    LAT_CNT_W=4, error-check helper function.
//  - Sub-module dmem_array: DEPTH x DATA_W storage, synchronous write enable, combinational
//    read port; no reset. dmem_responder holds the FSM, latency counter, request latch and
//    response registers.
// TESTING
//  1. Reset, LATENCY=2: store addr=0x10 data=0xDEADBEEF_CAFEF00D, then load 0x10 -> each
//     resp_valid exactly 2 cycles after accept; load resp_rdata=0xDEADBEEFCAFEF00D, err=0.
//  2. Misaligned load addr=0x13 and out-of-range store addr=DEPTH*8 -> resp_err=1,
//     resp_rdata=0; a following load of word DEPTH-1 returns its previous contents.
//  3. Backpressure: resp_ready low 5 cycles in RESP -> resp_valid/rdata held, req_ready=0,
//     a second req_valid is not accepted until the first response handshakes.
//  4. Reset pulse during WAIT of store to 0x20 (old value 0x1) -> resp_valid=0 at once,
//     IDLE after release; load 0x20 returns 0x1.
//  5. LATENCY=1 build, resp_ready tied high, 4 back-to-back loads -> accepts every 2
//     cycles, resp_valid the cycle after each accept.
//  6. Write/read-back sweep of all DEPTH words with data = ~index -> all reads match.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding,
// address decomposition constants and the request error check.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int WORD_OFS_BITS = 3;
    localparam int LAT_CNT_W     = 4;
    localparam int ERR_ADDR_W    = 128;

    // Address is zero-extended to a fixed width so one helper serves any ADDR_W.
    function automatic logic addr_err(input logic [ERR_ADDR_W-1:0] addr, input int depth);
        return (addr[WORD_OFS_BITS-1:0] != '0) ||
               ((addr >> WORD_OFS_BITS) >= ERR_ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage: synchronous write, combinational read, no reset
// so contents survive a responder reset.
module dmem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with fixed latency between request
// accept and response. Handshakes on both channels: a transfer happens on a
// rising edge where valid and ready are both high; the sender of valid holds
// its payload stable until that edge.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output state_t            dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dmem_responder: LATENCY must be in 1..15");
        end
        if (ADDR_W > ERR_ADDR_W || ADDR_W < WORD_OFS_BITS + IDX_W) begin : g_bad_addr_w
            $error("dmem_responder: ADDR_W cannot address DEPTH words");
        end
    endgenerate

    state_t                 state;
    logic [LAT_CNT_W-1:0]   cnt;
    logic                   lat_write;
    logic [ADDR_W-1:0]      lat_addr;
    logic [DATA_W-1:0]      lat_wdata;

    logic                   op_write;
    logic [ADDR_W-1:0]      op_addr;
    logic [DATA_W-1:0]      op_wdata;
    logic                   op_err;
    logic                   enter_resp;
    logic                   mem_we;
    logic [DATA_W-1:0]      rd_data;
    logic [DATA_W-1:0]      load_data;

    // With LATENCY==1 the accept edge is also the service edge, so the live
    // request inputs are used instead of the not-yet-written latch.
    always_comb begin
        op_write = lat_write;
        op_addr  = lat_addr;
        op_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            op_write = req_write;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end
    end

    assign op_err     = addr_err(ERR_ADDR_W'(op_addr), DEPTH);
    assign enter_resp = ((state == ST_IDLE) && req_valid && req_ready && (LATENCY == 1)) ||
                        ((state == ST_WAIT) && (cnt == LAT_CNT_W'(1)));
    assign mem_we     = enter_resp && op_write && !op_err;
    assign load_data  = (op_write || op_err) ? '0 : rd_data;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (op_addr[WORD_OFS_BITS +: IDX_W]),
        .wdata (op_wdata),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= op_err;
                            resp_rdata <= load_data;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= LAT_CNT_W'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == LAT_CNT_W'(1)) begin
                        state      <= ST_RESP;
                        cnt        <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= op_err;
                        resp_rdata <= load_data;
                    end else begin
                        cnt <= cnt - LAT_CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    cnt        <= '0;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule
